// File: rtl/temac_link_sequencer.sv
// temac_link_sequencer
//   AXI-lite master that brings the TEMAC up after a start pulse and then
//   keeps polling PHY register 1 (basic status) over the TEMAC MDIO
//   registers. link_ok mirrors the PHY link-status bit from the last poll.
//
// Ports
//   m_axi_aclk / m_axi_areset : clock, synchronous active-high reset
//   m_axi_aw* / m_axi_w* / m_axi_b* : AXI-lite write channels (master side)
//   m_axi_ar* / m_axi_r*      : AXI-lite read channels (master side)
//   start   : one-cycle start / restart request (honoured in IDLE or ERROR)
//   link_ok : registered PHY link status
//   busy    : high in every state except IDLE and ERROR
//   error   : sticky; set on a non-OKAY response or an MDIO ready timeout
module temac_link_sequencer #(
    parameter int                              C_M_AXI_ADDR_WIDTH = 32,
    parameter int                              C_M_AXI_DATA_WIDTH = 32,
    parameter logic [C_M_AXI_ADDR_WIDTH-1:0]   BASE_ADDR          = '0,
    parameter logic [4:0]                      PHY_ADDR           = 5'd1,
    parameter logic [5:0]                      MDIO_CLKDIV        = 6'd29,
    parameter int                              POLL_INTERVAL      = 1000000,
    parameter int                              MDIO_POLLS         = 64
) (
    input  logic                              m_axi_aclk,
    input  logic                              m_axi_areset,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]     m_axi_awaddr,
    output logic [2:0]                        m_axi_awprot,
    output logic                              m_axi_awvalid,
    input  logic                              m_axi_awready,
    output logic [C_M_AXI_DATA_WIDTH-1:0]     m_axi_wdata,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0]   m_axi_wstrb,
    output logic                              m_axi_wvalid,
    input  logic                              m_axi_wready,
    input  logic [1:0]                        m_axi_bresp,
    input  logic                              m_axi_bvalid,
    output logic                              m_axi_bready,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]     m_axi_araddr,
    output logic [2:0]                        m_axi_arprot,
    output logic                              m_axi_arvalid,
    input  logic                              m_axi_arready,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]     m_axi_rdata,
    input  logic [1:0]                        m_axi_rresp,
    input  logic                              m_axi_rvalid,
    output logic                              m_axi_rready,
    input  logic                              start,
    output logic                              link_ok,
    output logic                              busy,
    output logic                              error
);

    localparam int AW     = C_M_AXI_ADDR_WIDTH;
    localparam int DW     = C_M_AXI_DATA_WIDTH;
    localparam int POLL_W = (MDIO_POLLS    > 1) ? $clog2(MDIO_POLLS + 1)    : 1;
    localparam int WAIT_W = (POLL_INTERVAL > 1) ? $clog2(POLL_INTERVAL + 1) : 1;

    localparam logic [11:0] OFF_RCW  = 12'h404;
    localparam logic [11:0] OFF_TC   = 12'h408;
    localparam logic [11:0] OFF_MC   = 12'h500;
    localparam logic [11:0] OFF_MCMD = 12'h504;
    localparam logic [11:0] OFF_MRD  = 12'h50C;

    // MDIO setup: bit6 enables the MDIO interface, [5:0] is the clock divisor.
    localparam logic [31:0] SETUP_WORD = {25'b0, 1'b1, MDIO_CLKDIV};
    // MDIO control: PHYAD, REGAD=1 (status), OP=read, initiate.
    localparam logic [31:0] CMD_WORD   = {3'b0, PHY_ADDR, 3'b0, 5'd1, 2'b10, 2'b00, 1'b1, 11'b0};
    localparam logic [31:0] EN_WORD    = 32'h1000_0000;

    typedef enum logic [3:0] {
        S_IDLE, S_WR_SETUP, S_WR_RCW, S_WR_TC, S_MDIO_CMD,
        S_MDIO_POLL, S_MDIO_READ, S_WAIT, S_ERROR
    } state_t;

    state_t              state_q, state_d;
    logic                awvalid_q, awvalid_d, wvalid_q, wvalid_d, bready_q, bready_d;
    logic                arvalid_q, arvalid_d, rready_q, rready_d;
    logic [AW-1:0]       awaddr_q, awaddr_d, araddr_q, araddr_d;
    logic [DW-1:0]       wdata_q, wdata_d;
    logic                link_ok_q, link_ok_d, error_q, error_d;
    logic [POLL_W-1:0]   poll_cnt_q, poll_cnt_d;
    logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;

    // Launch requests raised by the FSM; applied after the case so every
    // transaction starts with its address/data and valids in the same cycle.
    logic                go_wr, go_rd, fail;
    logic [11:0]         go_off;
    logic [31:0]         go_data;

    always_ff @(posedge m_axi_aclk) begin
        if (m_axi_areset) begin
            state_q    <= S_IDLE;
            awvalid_q  <= 1'b0;
            wvalid_q   <= 1'b0;
            bready_q   <= 1'b0;
            arvalid_q  <= 1'b0;
            rready_q   <= 1'b0;
            awaddr_q   <= '0;
            araddr_q   <= '0;
            wdata_q    <= '0;
            link_ok_q  <= 1'b0;
            error_q    <= 1'b0;
            poll_cnt_q <= '0;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            awvalid_q  <= awvalid_d;
            wvalid_q   <= wvalid_d;
            bready_q   <= bready_d;
            arvalid_q  <= arvalid_d;
            rready_q   <= rready_d;
            awaddr_q   <= awaddr_d;
            araddr_q   <= araddr_d;
            wdata_q    <= wdata_d;
            link_ok_q  <= link_ok_d;
            error_q    <= error_d;
            poll_cnt_q <= poll_cnt_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        awvalid_d  = awvalid_q;
        wvalid_d   = wvalid_q;
        bready_d   = bready_q;
        arvalid_d  = arvalid_q;
        rready_d   = rready_q;
        awaddr_d   = awaddr_q;
        araddr_d   = araddr_q;
        wdata_d    = wdata_q;
        link_ok_d  = link_ok_q;
        error_d    = error_q;
        poll_cnt_d = poll_cnt_q;
        wait_cnt_d = wait_cnt_q;
        go_wr      = 1'b0;
        go_rd      = 1'b0;
        fail       = 1'b0;
        go_off     = '0;
        go_data    = '0;

        unique case (state_q)
            S_IDLE, S_ERROR: begin
                if (start) begin
                    state_d = S_WR_SETUP;
                    error_d = 1'b0;
                    go_wr   = 1'b1;
                    go_off  = OFF_MC;
                    go_data = SETUP_WORD;
                end
            end

            S_WR_SETUP, S_WR_RCW, S_WR_TC, S_MDIO_CMD: begin
                if (awvalid_q && m_axi_awready) awvalid_d = 1'b0;
                if (wvalid_q && m_axi_wready)   wvalid_d  = 1'b0;
                // bready goes up in the cycle after the later of AW/W completes.
                if (!bready_q && !awvalid_d && !wvalid_d) bready_d = 1'b1;
                if (bready_q && m_axi_bvalid) begin
                    bready_d = 1'b0;
                    if (m_axi_bresp != 2'b00) begin
                        fail = 1'b1;
                    end else begin
                        case (state_q)
                            S_WR_SETUP: begin
                                state_d = S_WR_RCW;
                                go_wr   = 1'b1;
                                go_off  = OFF_RCW;
                                go_data = EN_WORD;
                            end
                            S_WR_RCW: begin
                                state_d = S_WR_TC;
                                go_wr   = 1'b1;
                                go_off  = OFF_TC;
                                go_data = EN_WORD;
                            end
                            S_WR_TC: begin
                                state_d = S_MDIO_CMD;
                                go_wr   = 1'b1;
                                go_off  = OFF_MCMD;
                                go_data = CMD_WORD;
                            end
                            default: begin
                                state_d    = S_MDIO_POLL;
                                poll_cnt_d = '0;
                                go_rd      = 1'b1;
                                go_off     = OFF_MCMD;
                            end
                        endcase
                    end
                end
            end

            S_MDIO_POLL, S_MDIO_READ: begin
                if (arvalid_q && m_axi_arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                end
                if (rready_q && m_axi_rvalid) begin
                    rready_d = 1'b0;
                    if (m_axi_rresp != 2'b00) begin
                        fail = 1'b1;
                    end else if (state_q == S_MDIO_READ) begin
                        link_ok_d  = m_axi_rdata[2];
                        state_d    = S_WAIT;
                        wait_cnt_d = '0;
                    end else if (m_axi_rdata[7]) begin
                        state_d = S_MDIO_READ;
                        go_rd   = 1'b1;
                        go_off  = OFF_MRD;
                    end else begin
                        poll_cnt_d = poll_cnt_q + POLL_W'(1);
                        if (poll_cnt_d == POLL_W'(MDIO_POLLS)) begin
                            fail = 1'b1;
                        end else begin
                            go_rd  = 1'b1;
                            go_off = OFF_MCMD;
                        end
                    end
                end
            end

            S_WAIT: begin
                // Exactly POLL_INTERVAL cycles are spent here; the counter
                // stops at its terminal value because the state is left.
                if (wait_cnt_q == WAIT_W'(POLL_INTERVAL - 1)) begin
                    state_d = S_MDIO_CMD;
                    go_wr   = 1'b1;
                    go_off  = OFF_MCMD;
                    go_data = CMD_WORD;
                end else begin
                    wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                end
            end

            default: state_d = S_IDLE;
        endcase

        if (go_wr) begin
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            awaddr_d  = BASE_ADDR + AW'(go_off);
            wdata_d   = DW'(go_data);
        end
        if (go_rd) begin
            arvalid_d = 1'b1;
            araddr_d  = BASE_ADDR + AW'(go_off);
        end
        if (fail) begin
            state_d   = S_ERROR;
            error_d   = 1'b1;
            link_ok_d = 1'b0;
            awvalid_d = 1'b0;
            wvalid_d  = 1'b0;
            bready_d  = 1'b0;
            arvalid_d = 1'b0;
            rready_d  = 1'b0;
        end
    end

    // Only rdata bits 2 and 7 matter; fold the rest away for lint.
    logic unused_rdata;
    assign unused_rdata = ^m_axi_rdata;

    assign m_axi_awaddr  = awaddr_q;
    assign m_axi_awprot  = 3'b000;
    assign m_axi_awvalid = awvalid_q;
    assign m_axi_wdata   = wdata_q;
    assign m_axi_wstrb   = '1;
    assign m_axi_wvalid  = wvalid_q;
    assign m_axi_bready  = bready_q;
    assign m_axi_araddr  = araddr_q;
    assign m_axi_arprot  = 3'b000;
    assign m_axi_arvalid = arvalid_q;
    assign m_axi_rready  = rready_q;
    assign link_ok       = link_ok_q;
    assign error         = error_q;
    assign busy          = (state_q != S_IDLE) && (state_q != S_ERROR);

endmodule

// File: tb/tb_temac_link_sequencer.sv
// Directed bench for temac_link_sequencer: a small AXI-lite slave model with
// per-channel ready delays, a transaction log and one task per scenario.
module tb_temac_link_sequencer;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        areset, start;
    logic [31:0] awaddr, wdata, araddr, rdata;
    logic [2:0]  awprot, arprot;
    logic [3:0]  wstrb;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [1:0]  bresp, rresp;
    logic        link_ok, busy, error;

    int n_tests = 0;
    int n_fail  = 0;

    // slave knobs
    int          aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0;
    logic [31:0] err_addr = 32'hFFFF_FFFF;
    logic [31:0] ctrl_val = 32'h80;
    logic [31:0] phy_val  = 32'h796D;
    bit          slv_clr  = 0;

    // slave state and log
    bit          aw_fire, w_fire, aw_got, w_got, b_fire, ar_fire, ar_got, r_fire;
    int          aw_cnt, w_cnt, b_cnt, ar_cnt, aw_cyc, cyc;
    logic [31:0] cur_awaddr, cur_wdata, cur_araddr;
    logic [31:0] wr_addr[$], wr_data[$], rd_addr[$];
    int          wr_cyc[$];
    int          bready_early, dup_hs, w_first_seen;

    temac_link_sequencer #(
        .POLL_INTERVAL(10),
        .MDIO_POLLS   (4)
    ) dut (
        .m_axi_aclk   (clk),
        .m_axi_areset (areset),
        .m_axi_awaddr (awaddr),
        .m_axi_awprot (awprot),
        .m_axi_awvalid(awvalid),
        .m_axi_awready(awready),
        .m_axi_wdata  (wdata),
        .m_axi_wstrb  (wstrb),
        .m_axi_wvalid (wvalid),
        .m_axi_wready (wready),
        .m_axi_bresp  (bresp),
        .m_axi_bvalid (bvalid),
        .m_axi_bready (bready),
        .m_axi_araddr (araddr),
        .m_axi_arprot (arprot),
        .m_axi_arvalid(arvalid),
        .m_axi_arready(arready),
        .m_axi_rdata  (rdata),
        .m_axi_rresp  (rresp),
        .m_axi_rvalid (rvalid),
        .m_axi_rready (rready),
        .start        (start),
        .link_ok      (link_ok),
        .busy         (busy),
        .error        (error)
    );

    // Slave model, updated on the falling edge. A ready raised here means
    // the handshake happens on the next rising edge.
    initial begin
        awready = 0; wready = 0; bvalid = 0; bresp = 0;
        arready = 0; rvalid = 0; rresp = 0; rdata = 0;
        cyc = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (slv_clr) begin
                awready = 0; wready = 0; bvalid = 0; bresp = 0;
                arready = 0; rvalid = 0; rresp = 0;
                aw_fire = 0; w_fire = 0; aw_got = 0; w_got = 0; b_fire = 0;
                ar_fire = 0; ar_got = 0; r_fire = 0;
                aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0;
                slv_clr = 0;
            end else begin
                if (b_fire) begin bvalid = 0; bresp = 0; b_fire = 0; aw_got = 0; w_got = 0; b_cnt = 0; end
                if (aw_fire) begin awready = 0; aw_fire = 0; aw_got = 1; end
                if (w_fire)  begin wready = 0;  w_fire = 0;  w_got = 1;  end
                if (bready && !(aw_got && w_got)) bready_early++;
                if ((awvalid && aw_got) || (wvalid && w_got)) dup_hs++;
                if (!wvalid && awvalid && w_got && !aw_got) w_first_seen = 1;
                if (awvalid && !aw_got) begin
                    if (aw_cnt >= aw_dly) begin
                        awready = 1; aw_fire = 1; aw_cnt = 0; cur_awaddr = awaddr; aw_cyc = cyc;
                    end else aw_cnt++;
                end
                if (wvalid && !w_got) begin
                    if (w_cnt >= w_dly) begin
                        wready = 1; w_fire = 1; w_cnt = 0; cur_wdata = wdata;
                    end else w_cnt++;
                end
                if (aw_got && w_got && !bvalid) begin
                    if (b_cnt >= b_dly) begin
                        bvalid = 1;
                        bresp  = (cur_awaddr == err_addr) ? 2'b10 : 2'b00;
                        wr_addr.push_back(cur_awaddr);
                        wr_data.push_back(cur_wdata);
                        wr_cyc.push_back(aw_cyc);
                    end else b_cnt++;
                end
                if (bvalid && bready) b_fire = 1;

                if (r_fire)  begin rvalid = 0; r_fire = 0; ar_got = 0; end
                if (ar_fire) begin arready = 0; ar_fire = 0; ar_got = 1; end
                if (arvalid && ar_got) dup_hs++;
                if (arvalid && !ar_got) begin
                    if (ar_cnt >= ar_dly) begin
                        arready = 1; ar_fire = 1; ar_cnt = 0; cur_araddr = araddr;
                        rd_addr.push_back(araddr);
                    end else ar_cnt++;
                end
                if (ar_got && !rvalid) begin
                    rvalid = 1; rresp = 0;
                    rdata  = (cur_araddr == 32'h504) ? ctrl_val :
                             (cur_araddr == 32'h50C) ? phy_val  : 32'hDEAD_BEEF;
                end
                if (rvalid && rready) r_fire = 1;
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        areset = 1; start = 0; slv_clr = 1;
        tick();
        tick();
        areset = 0;
    endtask

    task automatic pulse_start();
        start = 1;
        tick();
        start = 0;
    endtask

    task automatic wait_wr(input int n, input int lim, output bit ok);
        ok = 0;
        for (int i = 0; i < lim; i++) begin
            if (wr_addr.size() >= n) begin ok = 1; break; end
            tick();
        end
    endtask

    // waits for the sample where the 0x50C read data is being accepted
    task automatic wait_phy_capture(input int lim, output bit ok);
        ok = 0;
        for (int i = 0; i < lim; i++) begin
            tick();
            if (rvalid && rready && araddr == 32'h50C) begin ok = 1; break; end
        end
    endtask

    task automatic test_reset();
        areset = 1; start = 1; slv_clr = 1;   // start together with reset: reset wins
        tick();
        tick();
        n_tests++;
        if ({awvalid, wvalid, bready, arvalid, rready, busy, error, link_ok} !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_ctrl got=%b want=00000000",
                     {awvalid, wvalid, bready, arvalid, rready, busy, error, link_ok});
        end
        n_tests++;
        if ({awaddr, wdata, araddr} !== 96'h0) begin
            n_fail++;
            $display("FAIL reset_regs aw=%h wd=%h ar=%h want 0", awaddr, wdata, araddr);
        end
        n_tests++;
        if ({awprot, arprot, wstrb} !== {3'b000, 3'b000, 4'hF}) begin
            n_fail++;
            $display("FAIL consts awprot=%b arprot=%b wstrb=%h", awprot, arprot, wstrb);
        end
        start = 0;
        areset = 0;
        tick();
        n_tests++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL start_in_reset busy=%b want 0", busy);
        end
    endtask

    task automatic test_bringup();
        logic [31:0] exp_a[4];
        logic [31:0] exp_d[4];
        int n0;
        bit ok;
        exp_a = '{32'h500, 32'h404, 32'h408, 32'h504};
        exp_d = '{32'h0000_005D, 32'h1000_0000, 32'h1000_0000, 32'h0101_8800};
        aw_dly = 0; w_dly = 0; b_dly = 0; ar_dly = 0;
        ctrl_val = 32'h80; phy_val = 32'h796D;
        n0 = wr_addr.size();
        pulse_start();
        n_tests++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL busy_after_start got=%b want 1", busy);
        end
        wait_wr(n0 + 4, 100, ok);
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL bringup_timeout writes=%0d want %0d", wr_addr.size() - n0, 4);
        end
        for (int i = 0; i < 4; i++) begin
            n_tests++;
            if (wr_addr[n0+i] !== exp_a[i] || wr_data[n0+i] !== exp_d[i]) begin
                n_fail++;
                $display("FAIL bringup_wr%0d got=%h:%h want=%h:%h", i,
                         wr_addr[n0+i], wr_data[n0+i], exp_a[i], exp_d[i]);
            end
        end
    endtask

    task automatic test_link_up();
        bit ok;
        wait_phy_capture(200, ok);
        n_tests++;
        if (!ok || link_ok !== 1'b0) begin
            n_fail++;
            $display("FAIL link_pre ok=%0d link_ok=%b want 0", ok, link_ok);
        end
        tick();
        n_tests++;
        if (link_ok !== 1'b1) begin
            n_fail++;
            $display("FAIL link_up link_ok=%b want 1", link_ok);
        end
        phy_val = 32'h7969;
        wait_phy_capture(200, ok);
        n_tests++;
        if (!ok || link_ok !== 1'b1 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL link_hold ok=%0d link_ok=%b busy=%b want 1 1", ok, link_ok, busy);
        end
        tick();
        n_tests++;
        if (link_ok !== 1'b0) begin
            n_fail++;
            $display("FAIL link_down link_ok=%b want 0", link_ok);
        end
    endtask

    // 0x504 command write (2) + control read (2) + data read (2) + 10 WAIT = 16
    task automatic test_poll_period();
        int n0;
        bit ok;
        n0 = wr_addr.size();
        wait_wr(n0 + 2, 200, ok);
        n_tests++;
        if (!ok || wr_addr[n0] !== 32'h504 || wr_addr[n0+1] !== 32'h504 ||
            (wr_cyc[n0+1] - wr_cyc[n0]) != 16) begin
            n_fail++;
            $display("FAIL poll_period ok=%0d a0=%h a1=%h gap=%0d want 16", ok,
                     wr_addr[n0], wr_addr[n0+1], wr_cyc[n0+1] - wr_cyc[n0]);
        end
    endtask

    task automatic test_reset_mid_poll();
        bit ok;
        phy_val = 32'h796D;
        ok = 0;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (link_ok === 1'b1) begin ok = 1; break; end
        end
        ar_dly = 6;
        if (ok) begin
            ok = 0;
            for (int i = 0; i < 100; i++) begin
                tick();
                if (arvalid && araddr == 32'h504) begin ok = 1; break; end
            end
        end
        areset = 1;
        tick();
        n_tests++;
        if (!ok || {awvalid, wvalid, bready, arvalid, rready, busy, error, link_ok} !== 8'h00 ||
            {awaddr, wdata, araddr} !== 96'h0) begin
            n_fail++;
            $display("FAIL reset_mid_poll ok=%0d ctrl=%b aw=%h wd=%h ar=%h want 0", ok,
                     {awvalid, wvalid, bready, arvalid, rready, busy, error, link_ok},
                     awaddr, wdata, araddr);
        end
        areset = 0; slv_clr = 1; ar_dly = 0;
        tick();
    endtask

    task automatic test_back_to_back();
        int n0;
        bit ok;
        do_reset();
        aw_dly = 3; w_dly = 0; b_dly = 2;
        bready_early = 0; dup_hs = 0; w_first_seen = 0;
        n0 = wr_addr.size();
        pulse_start();
        wait_wr(n0 + 4, 300, ok);
        n_tests++;
        if (!ok || w_first_seen != 1) begin
            n_fail++;
            $display("FAIL skew_w_first ok=%0d seen=%0d want 1", ok, w_first_seen);
        end
        n_tests++;
        if (bready_early != 0 || dup_hs != 0) begin
            n_fail++;
            $display("FAIL skew_protocol early_bready=%0d dup=%0d want 0 0", bready_early, dup_hs);
        end
        n_tests++;
        if (wr_addr[n0] !== 32'h500 || wr_addr[n0+1] !== 32'h404 ||
            wr_addr[n0+2] !== 32'h408 || wr_addr[n0+3] !== 32'h504) begin
            n_fail++;
            $display("FAIL skew_order got=%h %h %h %h want 500 404 408 504",
                     wr_addr[n0], wr_addr[n0+1], wr_addr[n0+2], wr_addr[n0+3]);
        end
        aw_dly = 0; b_dly = 0;
    endtask

    task automatic test_mdio_timeout();
        int r0, w1, r1, n504, n50c;
        bit ok;
        do_reset();
        ctrl_val = 32'h80; phy_val = 32'h796D;
        pulse_start();
        ok = 0;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (link_ok === 1'b1) begin ok = 1; break; end
        end
        ctrl_val = 32'h0;
        r0 = rd_addr.size();
        if (ok) begin
            ok = 0;
            for (int i = 0; i < 300; i++) begin
                tick();
                if (error === 1'b1) begin ok = 1; break; end
            end
        end
        n504 = 0; n50c = 0;
        for (int i = r0; i < rd_addr.size(); i++) begin
            if (rd_addr[i] == 32'h504) n504++;
            if (rd_addr[i] == 32'h50C) n50c++;
        end
        n_tests++;
        if (!ok || n504 != 4 || n50c != 0) begin
            n_fail++;
            $display("FAIL mdio_timeout ok=%0d reads504=%0d reads50c=%0d want 4 0", ok, n504, n50c);
        end
        n_tests++;
        if (error !== 1'b1 || busy !== 1'b0 || link_ok !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_flags err=%b busy=%b link=%b want 1 0 0", error, busy, link_ok);
        end
        w1 = wr_addr.size(); r1 = rd_addr.size();
        repeat (30) tick();
        n_tests++;
        if (wr_addr.size() != w1 || rd_addr.size() != r1 || error !== 1'b1) begin
            n_fail++;
            $display("FAIL timeout_quiet new_wr=%0d new_rd=%0d err=%b want 0 0 1",
                     wr_addr.size() - w1, rd_addr.size() - r1, error);
        end
        ctrl_val = 32'h80;
    endtask

    task automatic test_error_recovery();
        int n0, r0;
        bit ok;
        do_reset();
        err_addr = 32'h404;
        n0 = wr_addr.size();
        r0 = rd_addr.size();
        pulse_start();
        ok = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (error === 1'b1) begin ok = 1; break; end
        end
        n_tests++;
        if (!ok || busy !== 1'b0 || wr_addr.size() != n0 + 2 ||
            wr_addr[n0] !== 32'h500 || wr_addr[n0+1] !== 32'h404) begin
            n_fail++;
            $display("FAIL bresp_error ok=%0d busy=%b writes=%0d a0=%h a1=%h want 0 2 500 404",
                     ok, busy, wr_addr.size() - n0, wr_addr[n0], wr_addr[n0+1]);
        end
        repeat (20) tick();
        n_tests++;
        if (wr_addr.size() != n0 + 2 || rd_addr.size() != r0 || awvalid || arvalid) begin
            n_fail++;
            $display("FAIL error_quiet writes=%0d reads=%0d want 2 0",
                     wr_addr.size() - n0, rd_addr.size() - r0);
        end
        err_addr = 32'hFFFF_FFFF;
        pulse_start();
        n_tests++;
        if (error !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL recover_flags err=%b busy=%b want 0 1", error, busy);
        end
        wait_wr(n0 + 3, 100, ok);
        n_tests++;
        if (!ok || wr_addr[n0+2] !== 32'h500) begin
            n_fail++;
            $display("FAIL recover_restart ok=%0d addr=%h want 500", ok, wr_addr[n0+2]);
        end
    endtask

    initial begin
        areset = 1; start = 0;
        test_reset();
        test_bringup();
        test_link_up();
        test_poll_period();
        test_reset_mid_poll();
        test_back_to_back();
        test_mdio_timeout();
        test_error_recovery();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
